// File: rtl/ise_pkg.sv
// -----------------------------------------------------------------------------
// ise_pkg
// Shared definitions for the ISE pixel feeder:
//   - pixel word field widths (PIX_W, IDX_W, WORD_W)
//   - ise_word_t : packed pixel word {idx, rgb}
//   - ise_state_e: feeder FSM states
//   - total_words(): number of words streamed per run
// -----------------------------------------------------------------------------
package ise_pkg;

  localparam int PIX_W  = 24;
  localparam int IDX_W  = 5;
  localparam int WORD_W = 29;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [PIX_W-1:0] rgb;
  } ise_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } ise_state_e;

  function automatic int total_words(input int image_num, input int image_size);
    return image_num * image_size * image_size;
  endfunction

endpackage

// File: rtl/ise_feed_fifo.sv
// -----------------------------------------------------------------------------
// ise_feed_fifo
// Two-entry synchronous FIFO holding prefetched pixel words.
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset (empties the FIFO)
//   push_i   in   write wdata_i this cycle
//   wdata_i  in   word to write
//   pop_i    in   drop the head entry this cycle
//   rdata_o  out  head entry (valid when count_o != 0)
//   count_o  out  number of stored entries (0..2)
// A push and a pop in the same cycle leave the count unchanged.
// -----------------------------------------------------------------------------
module ise_feed_fifo
  import ise_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  ise_word_t  wdata_i,
  input  logic       pop_i,
  output ise_word_t  rdata_o,
  output logic [1:0] count_o
);

  ise_word_t  mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push_s;
  logic       do_pop_s;

  // Qualify requests against the current fill level.
  always_comb begin
    do_pop_s  = pop_i & (count_q != 2'd0);
    // A full FIFO can still accept a word when its head leaves in the same cycle.
    do_push_s = push_i & ((count_q != 2'd2) | do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ise_pixel_feeder.sv
// -----------------------------------------------------------------------------
// ise_pixel_feeder
// Streams IMAGE_NUM*IMAGE_SIZE*IMAGE_SIZE pixel words from a synchronous ROM
// (1-cycle read latency) into the ISE pixel input, honouring ISE busy.
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset, aborts any run
//   start          in   begins a run; honoured in IDLE and DONE only
//   rom_rd         out  ROM read strobe
//   rom_addr       out  ROM word address
//   rom_data       in   ROM data, valid the cycle after rom_rd
//   busy           in   ISE backpressure
//   image_in_index out  presented word bits [28:24]
//   pixel_in       out  presented word bits [23:0]
//   pix_valid      out  a word is presented
//   done           out  last word transferred; held until start/reset
//   word_cnt       out  words transferred this run (saturates at total)
//   stall_cnt      out  only with ISE_FEED_STALL_CNT_EN: cycles with
//                       pix_valid=1 and busy=1 this run (saturating)
// Build option: define ISE_FEED_STALL_CNT_EN to add the stall counter.
//
// Data path: ROM -> (bypass or 2-entry FIFO) -> output register. A read is
// issued only if, after this cycle's move into the output register, fewer
// than two words would be pending in FIFO plus ROM pipeline; the output
// register plus FIFO can therefore always absorb every outstanding read.
// -----------------------------------------------------------------------------
module ise_pixel_feeder
  import ise_pkg::*;
#(
  parameter int IMAGE_NUM  = 32,
  parameter int IMAGE_SIZE = 128,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  input  logic              busy,
  output logic [IDX_W-1:0]  image_in_index,
  output logic [PIX_W-1:0]  pixel_in,
  output logic              pix_valid,
  output logic              done,
`ifdef ISE_FEED_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic [ADDR_W:0]   word_cnt
);

  localparam int              TOTAL   = total_words(IMAGE_NUM, IMAGE_SIZE);
  localparam logic [ADDR_W:0] TOTAL_W = (ADDR_W+1)'(TOTAL);
  localparam logic [ADDR_W:0] LAST_W  = TOTAL_W - {{ADDR_W{1'b0}}, 1'b1};

  ise_state_e        state_q;
  logic              rom_rd_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic              land_q;      // rom_data carries a requested word this cycle
  logic [ADDR_W:0]   rd_ptr_q;    // reads issued this run
  ise_word_t         word_q;
  logic              pix_valid_q;
  logic              done_q;
  logic [ADDR_W:0]   word_cnt_q;
`ifdef ISE_FEED_STALL_CNT_EN
  logic [31:0]       stall_cnt_q;
`endif

  ise_word_t  fifo_rdata_s;
  logic [1:0] fifo_count_s;
  logic       fifo_push_s;
  logic       fifo_pop_s;
  logic       active_s;
  logic       consume_s;
  logic       slot_free_s;
  logic       fifo_has_s;
  logic       load_s;
  logic       load_fifo_s;
  logic       load_rom_s;
  logic       last_s;
  logic [2:0] pend_s;
  logic [2:0] pend_after_s;
  logic       issue_s;

  ise_feed_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push_s),
    .wdata_i (ise_word_t'(rom_data)),
    .pop_i   (fifo_pop_s),
    .rdata_o (fifo_rdata_s),
    .count_o (fifo_count_s)
  );

  // Transfer, output-refill and read-issue decisions for this cycle.
  always_comb begin
    active_s     = (state_q == FILL) || (state_q == SEND);
    consume_s    = pix_valid_q & ~busy;
    slot_free_s  = ~pix_valid_q | consume_s;
    fifo_has_s   = (fifo_count_s != 2'd0);
    load_s       = active_s & slot_free_s & (fifo_has_s | land_q);
    // FIFO holds older words than the one landing now, so it drains first.
    load_fifo_s  = load_s & fifo_has_s;
    load_rom_s   = load_s & ~fifo_has_s;
    fifo_pop_s   = load_fifo_s;
    fifo_push_s  = active_s & land_q & ~load_rom_s;
    last_s       = active_s & consume_s & (word_cnt_q == LAST_W);
    pend_s       = {1'b0, fifo_count_s} + {2'b00, land_q} + {2'b00, rom_rd_q};
    pend_after_s = pend_s - {2'b00, load_s};
    issue_s      = active_s & (pend_after_s < 3'd2) & (rd_ptr_q < TOTAL_W);
  end

  // Feeder FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      land_q      <= 1'b0;
      rd_ptr_q    <= '0;
      word_q      <= '0;
      pix_valid_q <= 1'b0;
      done_q      <= 1'b0;
      word_cnt_q  <= '0;
`ifdef ISE_FEED_STALL_CNT_EN
      stall_cnt_q <= 32'd0;
`endif
    end else begin
      land_q <= rom_rd_q;
      case (state_q)
        IDLE, DONE: begin
          rom_rd_q    <= 1'b0;
          pix_valid_q <= 1'b0;
          if (start) begin
            // First read goes out together with the state change.
            state_q    <= FILL;
            done_q     <= 1'b0;
            word_cnt_q <= '0;
            rom_rd_q   <= 1'b1;
            rom_addr_q <= '0;
            rd_ptr_q   <= {{ADDR_W{1'b0}}, 1'b1};
`ifdef ISE_FEED_STALL_CNT_EN
            stall_cnt_q <= 32'd0;
`endif
          end
        end
        FILL, SEND: begin
          rom_rd_q <= issue_s;
          if (issue_s) begin
            rom_addr_q <= rd_ptr_q[ADDR_W-1:0];
            rd_ptr_q   <= rd_ptr_q + {{ADDR_W{1'b0}}, 1'b1};
          end
          if (consume_s && (word_cnt_q != TOTAL_W)) begin
            word_cnt_q <= word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
          end
`ifdef ISE_FEED_STALL_CNT_EN
          if (pix_valid_q && busy && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
          end
`endif
          if (last_s) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            pix_valid_q <= 1'b0;
          end else if (load_s) begin
            pix_valid_q <= 1'b1;
            word_q      <= load_fifo_s ? fifo_rdata_s : ise_word_t'(rom_data);
            state_q     <= SEND;
          end else if (consume_s) begin
            // Underflow bubble: data fields keep the last word.
            pix_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rom_rd         = rom_rd_q;
  assign rom_addr       = rom_addr_q;
  assign image_in_index = word_q.idx;
  assign pixel_in       = word_q.rgb;
  assign pix_valid      = pix_valid_q;
  assign done           = done_q;
  assign word_cnt       = word_cnt_q;
`ifdef ISE_FEED_STALL_CNT_EN
  assign stall_cnt      = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ise_pixel_feeder.sv
// Bench for ise_pixel_feeder: 1 image of 4x4 pixels, ROM model with 1-cycle
// latency, scoreboard queue filled at start and drained on each transfer.
module tb_ise_pixel_feeder;

  localparam int ADDR_W = 4;
  localparam int NWORDS = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy;
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [28:0]       rom_data;
  logic [4:0]        image_in_index;
  logic [23:0]       pixel_in;
  logic              pix_valid;
  logic              done;
  logic [ADDR_W:0]   word_cnt;
`ifdef ISE_FEED_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [28:0] exp_q[$];
  int          cyc = 0;
  int          t0 = 0;
  int          done_rel = -1;
  int          rd_total = 0;
  int          xfers = 0;
  int          max_ahead = 0;
  bit          dut_idle = 1'b1;
  bit          first_seen = 1'b0;
  bit          prev_stall = 1'b0;
  bit          prev_done = 1'b0;
  logic [28:0] prev_word = 29'd0;

  always #5 clk = ~clk;

  ise_pixel_feeder #(
    .IMAGE_NUM  (1),
    .IMAGE_SIZE (4),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .rom_rd         (rom_rd),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .busy           (busy),
    .image_in_index (image_in_index),
    .pixel_in       (pixel_in),
    .pix_valid      (pix_valid),
    .done           (done),
`ifdef ISE_FEED_STALL_CNT_EN
    .stall_cnt      (stall_cnt),
`endif
    .word_cnt       (word_cnt)
  );

  function automatic logic [28:0] rom_word(input int a);
    logic [28:0] w;
    w[28:24] = a[4:0];
    w[23:0]  = 24'hA50000 | a[23:0];
    return w;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ROM: data valid one cycle after the read; garbage otherwise.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rom_data <= rom_rd ? rom_word(int'(rom_addr)) : 29'h1FFF_FFFF;
  end

  // Monitor, sampling on the falling edge.
  initial begin
    int ahead;
    logic [28:0] exp_w;
    forever begin
      @(negedge clk);
      if (reset) begin
        dut_idle   = 1'b1;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (start && dut_idle) begin
          t0 = cyc + 1; dut_idle = 1'b0; first_seen = 1'b0;
          rd_total = 0; xfers = 0; max_ahead = 0; done_rel = -1;
        end
        if (rom_rd) begin
          check_val("rom_addr", rom_addr, rd_total);
          rd_total++;
        end
        ahead = rd_total - xfers - (pix_valid ? 1 : 0);
        if (ahead > max_ahead) max_ahead = ahead;
        if (prev_stall) begin
          check_val("hold_valid", pix_valid, 1'b1);
          check_val("hold_data", {image_in_index, pixel_in}, prev_word);
        end
        if (pix_valid && !first_seen) begin
          check_val("first_latency", cyc - t0, 2);
          first_seen = 1'b1;
        end
        if (done && !prev_done) begin
          done_rel = cyc - t0;
          check_val("done_pix_valid", pix_valid, 1'b0);
          dut_idle = 1'b1;
        end
        if (pix_valid && !busy) begin
          if (exp_q.size() == 0) begin
            check_val("sb_empty", 1, 0);
          end else begin
            exp_w = exp_q.pop_front();
            check_val("word", {image_in_index, pixel_in}, exp_w);
          end
          xfers++;
        end
        prev_stall = pix_valid && busy;
        prev_word  = {image_in_index, pixel_in};
        prev_done  = done;
      end
    end
  end

  function automatic logic busy_for(input int mode, input int rel);
    case (mode)
      1:       return (rel >= 5) && (rel <= 9);
      2:       return (rel % 2) == 1;
      3:       return (rel >= 17) && (rel <= 20);
      default: return 1'b0;
    endcase
  endfunction

  // One full run. mode 0: busy low; 1: busy cycles 5..9; 2: alternating;
  // 3: hold last word; 4: stray start pulse mid-run.
  task automatic run_stream(input int mode, input int exp_done, input int exp_stall);
    int rel;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1;
    busy  = 1'b0;
    for (int i = 0; i < NWORDS; i++) exp_q.push_back(rom_word(i));
    @(posedge clk); #1;
    start = 1'b0;
    check_val("done_cleared", done, 1'b0);
    rel  = 0;
    seen = 1'b0;
    while (!seen && rel < 200) begin
      busy  = busy_for(mode, rel);
      start = (mode == 4) && (rel == 5);
      if (mode == 3 && rel >= 17 && rel <= 20) begin
        check_val("last_hold_idx", image_in_index, 5'd15);
        check_val("last_hold_done", done, 1'b0);
        check_val("last_hold_rd", rom_rd, 1'b0);
      end
      @(posedge clk); #1;
      rel++;
      seen = done;
    end
    busy  = 1'b0;
    start = 1'b0;
    check_val("timeout", seen, 1'b1);
    @(negedge clk); #1;
    check_val("done_cycle", done_rel, exp_done);
    check_val("word_cnt", word_cnt, NWORDS);
    check_val("end_pix_valid", pix_valid, 1'b0);
    check_val("sb_leftover", exp_q.size(), 0);
    check_val("max_ahead", max_ahead, 2);
`ifdef ISE_FEED_STALL_CNT_EN
    check_val("stall_cnt", stall_cnt, exp_stall);
`else
    if (exp_stall < 0) check_val("stall_arg", exp_stall, 0);
`endif
  endtask

  task automatic reset_midrun();
    @(posedge clk); #1;
    start = 1'b1;
    busy  = 1'b0;
    for (int i = 0; i < NWORDS; i++) exp_q.push_back(rom_word(i));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_val("pre_reset_idx", image_in_index, 5'd7);
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("rst_mid_rd", rom_rd, 1'b0);
    check_val("rst_mid_addr", rom_addr, '0);
    check_val("rst_mid_idx", image_in_index, 5'd0);
    check_val("rst_mid_pix", pixel_in, 24'd0);
    check_val("rst_mid_valid", pix_valid, 1'b0);
    check_val("rst_mid_done", done, 1'b0);
    check_val("rst_mid_cnt", word_cnt, '0);
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check_val("post_reset_valid", pix_valid, 1'b0);
    check_val("post_reset_rd", rom_rd, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    busy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_rd", rom_rd, 1'b0);
    check_val("rst_addr", rom_addr, '0);
    check_val("rst_idx", image_in_index, 5'd0);
    check_val("rst_pix", pixel_in, 24'd0);
    check_val("rst_valid", pix_valid, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_cnt", word_cnt, '0);
`ifdef ISE_FEED_STALL_CNT_EN
    check_val("rst_stall", stall_cnt, 32'd0);
`endif
    reset = 1'b0;
    run_stream(0, 18, 0);
    run_stream(1, 23, 5);
    run_stream(2, 33, 15);
    run_stream(3, 22, 4);
    run_stream(4, 18, 0);
    run_stream(0, 18, 0);
    reset_midrun();
    run_stream(0, 18, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
